// File: rtl/freq_meter_pkg.sv
// Shared constants for the frequency-meter control slice: sequencer states,
// decade table and counter width helper.
package freq_meter_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_CLEAR  = 3'd1;
  localparam state_t S_GATE   = 3'd2;
  localparam state_t S_SETTLE = 3'd3;
  localparam state_t S_SAVE   = 3'd4;

  localparam int unsigned DEC [0:3] = '{1, 10, 100, 1000};

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Gate length timer: a base counter (0..GATE_BASE-1) feeding a decade counter
// (0..10^range-1); pulses done on the last cycle of the gate.
module gate_timer
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_BASE = 1000,
  parameter int unsigned NRANGE    = 4,
  parameter int unsigned RW        = 2
) (
  input  logic          c_clk,
  input  logic          reset,
  input  logic          start,
  input  logic [RW-1:0] range,
  output logic          done
);

  localparam int unsigned BW = cnt_w(GATE_BASE);
  localparam int unsigned DW = cnt_w(DEC[NRANGE-1]);
  localparam logic [BW-1:0] BASE_TC = BW'(GATE_BASE - 1);

  logic          active;
  logic [BW-1:0] base_cnt;
  logic [DW-1:0] dec_cnt;
  logic [DW-1:0] dec_tc;
  logic [1:0]    ridx;

  assign ridx   = 2'(range);
  assign dec_tc = DW'(DEC[ridx] - 1);
  assign done   = active && (base_cnt == BASE_TC) && (dec_cnt == dec_tc);

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      active   <= 1'b0;
      base_cnt <= '0;
      dec_cnt  <= '0;
    end else if (start) begin
      active   <= 1'b1;
      base_cnt <= '0;
      dec_cnt  <= '0;
    end else if (active) begin
      // Terminal count returns both counters to zero so neither ever wraps.
      if (done) begin
        active   <= 1'b0;
        base_cnt <= '0;
        dec_cnt  <= '0;
      end else if (base_cnt == BASE_TC) begin
        base_cnt <= '0;
        dec_cnt  <= dec_cnt + 1'b1;
      end else begin
        base_cnt <= base_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/freq_gate_seq.sv
// Gate/clear/save sequencer for the frequency meter with decade ranging,
// manual or auto-ranged from the counter overflow/under-range flags.
module freq_gate_seq
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_BASE     = 1000,
  parameter int unsigned NRANGE        = 4,
  parameter int unsigned RW            = 2,
  parameter int unsigned CLR_CYCLES    = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic          c_clk,
  input  logic          reset,
  input  logic          run,
  input  logic          single,
  input  logic          auto_rng,
  input  logic [RW-1:0] rng_sel,
  input  logic          ovf,
  input  logic          under,
  output logic          w_enable,
  output logic          clear,
  output logic          save,
  output logic          busy,
  output logic [RW-1:0] rng
);

  localparam int unsigned PW =
    cnt_w((CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES);
  localparam logic [PW-1:0] CLR_TC = PW'(CLR_CYCLES - 1);
  localparam logic [PW-1:0] SET_TC = PW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(NRANGE - 1);

  state_t        state, nxt;
  logic [PW-1:0] ph;
  logic [RW-1:0] cur_r, next_r, start_r, upd_r;
  logic          ovf_flag, gate_done, clr_end, set_end, go;

  assign clr_end = (state == S_CLEAR)  && (ph == CLR_TC);
  assign set_end = (state == S_SETTLE) && (ph == SET_TC);
  assign go      = (nxt == S_CLEAR) && (state != S_CLEAR);
  assign start_r = auto_rng ? next_r : ((rng_sel > R_MAX) ? R_MAX : rng_sel);

  gate_timer #(
    .GATE_BASE(GATE_BASE),
    .NRANGE   (NRANGE),
    .RW       (RW)
  ) u_timer (
    .c_clk(c_clk),
    .reset(reset),
    .start(clr_end),
    .range(cur_r),
    .done (gate_done)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (run || single) nxt = S_CLEAR;
      S_CLEAR:  if (clr_end)       nxt = S_GATE;
      S_GATE:   if (gate_done)     nxt = S_SETTLE;
      S_SETTLE: if (set_end)       nxt = S_SAVE;
      S_SAVE:   nxt = run ? S_CLEAR : S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Overflow outranks under-range; both saturate at the range ends.
  always_comb begin
    upd_r = cur_r;
    if (ovf_flag && (cur_r != '0))
      upd_r = cur_r - 1'b1;
    else if (under && (cur_r < R_MAX))
      upd_r = cur_r + 1'b1;
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      ph       <= '0;
      cur_r    <= '0;
      next_r   <= '0;
      ovf_flag <= 1'b0;
      rng      <= '0;
      w_enable <= 1'b0;
      clear    <= 1'b0;
      save     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state)
        ph <= '0;
      else if ((state == S_CLEAR) || (state == S_SETTLE))
        ph <= ph + 1'b1;
      if (go)
        cur_r <= start_r;
      if (state == S_CLEAR)
        ovf_flag <= 1'b0;
      else if ((state == S_GATE) && ovf)
        ovf_flag <= 1'b1;
      // Range result and next-range decision are taken on the edge into
      // SAVE, so rng is already valid while save is high.
      if (set_end) begin
        rng <= cur_r;
        if (auto_rng)
          next_r <= upd_r;
      end
      w_enable <= (nxt == S_GATE);
      clear    <= (nxt == S_CLEAR);
      save     <= (nxt == S_SAVE);
      busy     <= (nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_freq_gate_seq.sv
// Self-checking bench for freq_gate_seq: a queue-based measurement model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_freq_gate_seq;

  localparam int GB  = 4;
  localparam int NR  = 4;
  localparam int RWD = 2;
  localparam int CLR = 2;
  localparam int SET = 1;

  logic c_clk = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0, single = 1'b0, auto_rng = 1'b0, ovf = 1'b0, under = 1'b0;
  logic [RWD-1:0] rng_sel = '0;
  logic w_enable, clear, save, busy;
  logic [RWD-1:0] rng;

  always #5 c_clk = ~c_clk;

  freq_gate_seq #(
    .GATE_BASE    (GB),
    .NRANGE       (NR),
    .RW           (RWD),
    .CLR_CYCLES   (CLR),
    .SETTLE_CYCLES(SET)
  ) dut (
    .c_clk   (c_clk),
    .reset   (reset),
    .run     (run),
    .single  (single),
    .auto_rng(auto_rng),
    .rng_sel (rng_sel),
    .ovf     (ovf),
    .under   (under),
    .w_enable(w_enable),
    .clear   (clear),
    .save    (save),
    .busy    (busy),
    .rng     (rng)
  );

  typedef struct {
    bit clr;
    bit w;
    bit sv;
    bit bsy;
    bit last;
    int r;
  } ent_t;

  // Model: each started measurement is expanded into its expected cycle list.
  ent_t q[$];
  ent_t cur = '{default: 0};
  int   m_rng = 0, next_r = 0;
  bit   ovf_seen = 0, under_seen = 0, auto_seen = 0;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, w_cnt = 0, c_cnt = 0, last_wlen = 0, last_clen = 0;
  int n_save = 0, n_clr = 0, last_save_rng = -1, last_save_cyc = 0, save_gap = 0;
  bit obs_w = 0, obs_busy = 0, prev_clear = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic start_meas();
    int   r, g;
    ent_t e;
    r = auto_rng ? next_r : ((int'(rng_sel) > NR - 1) ? NR - 1 : int'(rng_sel));
    g = GB;
    for (int k = 0; k < r; k++) g = g * 10;
    ovf_seen = 0;
    e = '{default: 0};
    e.r = r;
    e.bsy = 1;
    e.clr = 1;
    repeat (CLR) q.push_back(e);
    e.clr = 0;
    e.w = 1;
    repeat (g) q.push_back(e);
    e.w = 0;
    for (int k = 0; k < SET; k++) begin
      e.last = (k == SET - 1);
      q.push_back(e);
    end
    e.last = 0;
    e.sv = 1;
    q.push_back(e);
  endtask

  task automatic step();
    @(negedge c_clk);
    if (!reset) begin
      chk("rst_w_enable", int'(w_enable), 0);
      chk("rst_clear", int'(clear), 0);
      chk("rst_save", int'(save), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_rng", int'(rng), 0);
      q.delete();
      cur = '{default: 0};
      m_rng = 0; next_r = 0;
      ovf_seen = 0; under_seen = 0; auto_seen = 0;
    end else begin
      chk("w_enable", int'(w_enable), int'(cur.w));
      chk("clear", int'(clear), int'(cur.clr));
      chk("save", int'(save), int'(cur.sv));
      chk("busy", int'(busy), int'(cur.bsy));
      chk("rng", int'(rng), m_rng);
      if (cur.w && ovf) ovf_seen = 1;
      if (cur.last) begin
        under_seen = under;
        auto_seen = auto_rng;
      end
      if (cur.sv) begin
        if (auto_seen) begin
          if (ovf_seen && cur.r > 0) next_r = cur.r - 1;
          else if (under_seen && cur.r < NR - 1) next_r = cur.r + 1;
        end
        if (run) start_meas();
      end else if (!cur.bsy && (run || single)) begin
        start_meas();
      end
      if (q.size() > 0) begin
        cur = q.pop_front();
        if (cur.sv) m_rng = cur.r;
      end else begin
        cur = '{default: 0};
      end
    end
    obs_w = w_enable;
    obs_busy = busy;
    if (w_enable) w_cnt++;
    else if (w_cnt > 0) begin last_wlen = w_cnt; w_cnt = 0; end
    if (clear) c_cnt++;
    else if (c_cnt > 0) begin last_clen = c_cnt; c_cnt = 0; end
    if (clear && !prev_clear) n_clr++;
    prev_clear = clear;
    if (save) begin
      n_save++;
      last_save_rng = int'(rng);
      save_gap = cyc - last_save_cyc;
      last_save_cyc = cyc;
    end
    cyc++;
    @(posedge c_clk);
    #1;
  endtask

  task automatic wait_save(input int lim);
    int s0 = n_save;
    int i = 0;
    while (n_save == s0 && i < lim) begin
      step();
      i++;
    end
    chk("save_seen", int'(n_save != s0), 1);
  endtask

  task automatic wait_w(input int lim);
    int i = 0;
    do begin
      step();
      i++;
    end while (!obs_w && i < lim);
    chk("gate_seen", int'(obs_w), 1);
  endtask

  task automatic meas(input bit do_ovf, input bit und, output int r_out);
    under = und;
    single = 1;
    step();
    single = 0;
    wait_w(20);
    if (do_ovf) begin
      ovf = 1;
      step();
      ovf = 0;
    end
    wait_save(5000);
    r_out = last_save_rng;
    under = 0;
    step();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, s0, c0, i;

    // Reset, then idle with no start
    repeat (3) step();
    reset = 1;
    repeat (100) step();
    chk("idle_saves", n_save, 0);
    chk("idle_clears", n_clr, 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_rng", int'(rng), 0);

    // Manual single-shot at range 1
    rng_sel = 1;
    single = 1;
    step();
    single = 0;
    wait_save(200);
    chk("t2_busy_after", int'(busy), 0);
    step();
    chk("t2_clear_len", last_clen, 2);
    chk("t2_gate_len", last_wlen, 40);
    chk("t2_save_rng", last_save_rng, 1);
    chk("t2_saves", n_save, 1);

    // Continuous at range 0, then drop run mid-gate
    rng_sel = 0;
    run = 1;
    wait_save(100);
    wait_save(100);
    chk("t3_period", save_gap, 8);
    wait_save(100);
    chk("t3_period2", save_gap, 8);
    chk("t3_rng", last_save_rng, 0);
    wait_w(20);
    run = 0;
    s0 = n_save;
    c0 = n_clr;
    repeat (30) step();
    chk("t3_drop_saves", n_save - s0, 1);
    chk("t3_drop_clears", n_clr - c0, 0);
    chk("t3_idle_busy", int'(busy), 0);

    // Auto-ranging
    auto_rng = 1;
    meas(0, 1, r); chk("t4_climb_a", r, 0);
    meas(0, 1, r); chk("t4_climb_b", r, 1);
    meas(1, 0, r); chk("t4_ovf_at_r2", r, 2);
    meas(0, 0, r); chk("t4_after_ovf", r, 1);
    chk("t4_gate_after_ovf", last_wlen, 40);
    meas(0, 1, r); meas(0, 1, r);
    meas(0, 1, r); chk("t4_reach_r3", r, 3);
    meas(0, 1, r); chk("t4_under_sat_r3", r, 3);
    meas(1, 0, r); meas(1, 0, r);
    meas(1, 0, r); chk("t4_down_r1", r, 1);
    meas(1, 0, r); chk("t4_at_r0", r, 0);
    meas(0, 0, r); chk("t4_ovf_sat_r0", r, 0);
    meas(0, 1, r);
    meas(1, 1, r); chk("t4_both_at_r1", r, 1);
    meas(0, 0, r); chk("t4_ovf_priority", r, 0);

    // Randomised traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) begin
        run = ($urandom_range(0, 2) == 0);
        auto_rng = $urandom_range(0, 1);
        rng_sel = RWD'($urandom_range(0, 3));
      end
      single = ($urandom_range(0, 15) == 0);
      ovf = ($urandom_range(0, 31) == 0);
      under = ($urandom_range(0, 3) == 0);
      step();
    end
    run = 0; single = 0; ovf = 0; under = 0; auto_rng = 0;
    i = 0;
    do begin
      step();
      i++;
    end while (obs_busy && i < 6000);
    chk("drain_idle", int'(obs_busy), 0);

    // Asynchronous reset in the middle of a gate
    rng_sel = 2;
    single = 1;
    step();
    single = 0;
    wait_w(20);
    repeat (5) step();
    chk("t5_w_before", int'(w_enable), 1);
    #2 reset = 0;
    #1;
    chk("t5_w_async", int'(w_enable), 0);
    chk("t5_busy_async", int'(busy), 0);
    repeat (2) step();
    reset = 1;
    s0 = n_save;
    repeat (20) step();
    chk("t5_rng_after", int'(rng), 0);
    chk("t5_busy_after", int'(busy), 0);
    chk("t5_no_save", n_save - s0, 0);

    // single during GATE is ignored; rng_sel change applies next time
    rng_sel = 0;
    single = 1;
    step();
    single = 0;
    wait_w(20);
    s0 = n_save;
    single = 1;
    rng_sel = 1;
    step();
    single = 0;
    wait_save(100);
    repeat (20) step();
    chk("t6_one_save", n_save - s0, 1);
    chk("t6_rng_old", last_save_rng, 0);
    chk("t6_wlen_old", last_wlen, 4);
    single = 1;
    step();
    single = 0;
    wait_save(200);
    step();
    chk("t6_rng_new", last_save_rng, 1);
    chk("t6_wlen_new", last_wlen, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
